// File: rtl/group_mac.sv
// Grouped signed multiply-accumulate: partitions MAX_MACS lane products into contiguous groups
// and emits one sign-extended dot product per group, fully pipelined with a fixed 3-cycle latency.
module group_mac #(
    parameter int unsigned MAX_MACS          = 64,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned MAX_GROUPS        = 8,
    parameter int unsigned MAC_BIT_PER_GROUP = 6
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [$clog2(MAX_GROUPS+1)-1:0]         num_groups,
    input  logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] num_macs_i,
    input  logic                                    valid_in,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]          data,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]          weight,
    output logic [MAX_GROUPS*4*DATA_WIDTH-1:0]      mac_out,
    output logic                                    valid_out
);

    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned MBPG   = MAC_BIT_PER_GROUP;
    localparam int unsigned NGW    = $clog2(MAX_GROUPS + 1);
    localparam int unsigned OW     = $clog2(MAX_GROUPS * ((1 << MBPG) - 1) + 1);
    localparam int unsigned GW     = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;
    localparam int unsigned PRW    = 2 * DW;
    localparam int unsigned NCHUNK = (MAX_MACS % 8 == 0) ? 8 : 1;
    localparam int unsigned CHUNK  = MAX_MACS / NCHUNK;
    localparam int unsigned PW     = PRW + $clog2(CHUNK) + 1;
    localparam int unsigned SW     = 4 * DW;

    // Stage 1: clamp the group count and turn lane counts into [lo, hi) lane windows.
    logic [NGW-1:0] ng_clamp;
    logic [OW-1:0]  run;
    logic [OW-1:0]  lo_d [MAX_GROUPS];
    logic [OW-1:0]  hi_d [MAX_GROUPS];

    always_comb begin
        ng_clamp = (num_groups > NGW'(MAX_GROUPS)) ? NGW'(MAX_GROUPS) : num_groups;
        run      = '0;
        for (int g = 0; g < MAX_GROUPS; g++) begin
            lo_d[g] = run;
            hi_d[g] = run;
            // Inactive groups get an empty window, so their count fields never matter.
            if (NGW'(g) < ng_clamp) begin
                run     = run + OW'(num_macs_i[g*MBPG +: MBPG]);
                hi_d[g] = run;
            end
        end
    end

    logic                         v1_q;
    logic [MAX_MACS*DW-1:0]       d1_q;
    logic [MAX_MACS*DW-1:0]       w1_q;
    logic [OW-1:0]                lo_q [MAX_GROUPS];
    logic [OW-1:0]                hi_q [MAX_GROUPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            w1_q <= '0;
            for (int g = 0; g < MAX_GROUPS; g++) begin
                lo_q[g] <= '0;
                hi_q[g] <= '0;
            end
        end else begin
            v1_q <= valid_in;
            if (valid_in) begin
                d1_q <= data;
                w1_q <= weight;
                for (int g = 0; g < MAX_GROUPS; g++) begin
                    lo_q[g] <= lo_d[g];
                    hi_q[g] <= hi_d[g];
                end
            end
        end
    end

    // Stage 2: per-lane product, zeroed unless the lane falls inside some active window.
    logic signed [PRW-1:0] prod_d [MAX_MACS];
    logic [GW-1:0]         grp_d  [MAX_MACS];

    always_comb begin
        for (int i = 0; i < MAX_MACS; i++) begin
            prod_d[i] = '0;
            grp_d[i]  = '0;
            for (int g = 0; g < MAX_GROUPS; g++) begin
                if (i >= int'(lo_q[g]) && i < int'(hi_q[g])) begin
                    grp_d[i]  = GW'(g);
                    prod_d[i] = PRW'($signed(d1_q[i*DW +: DW])) *
                                PRW'($signed(w1_q[i*DW +: DW]));
                end
            end
        end
    end

    logic                  v2_q;
    logic signed [PRW-1:0] prod_q [MAX_MACS];
    logic [GW-1:0]         grp_q  [MAX_MACS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
            for (int i = 0; i < MAX_MACS; i++) begin
                prod_q[i] <= '0;
                grp_q[i]  <= '0;
            end
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int i = 0; i < MAX_MACS; i++) begin
                    prod_q[i] <= prod_d[i];
                    grp_q[i]  <= grp_d[i];
                end
            end
        end
    end

    // Stage 3a: per-group partial sums over fixed lane chunks.
    logic signed [PW-1:0] part_d [MAX_GROUPS][NCHUNK];

    always_comb begin
        for (int g = 0; g < MAX_GROUPS; g++) begin
            for (int c = 0; c < NCHUNK; c++) begin
                part_d[g][c] = '0;
                for (int k = 0; k < CHUNK; k++) begin
                    if (grp_q[c*CHUNK+k] == GW'(g)) begin
                        part_d[g][c] = part_d[g][c] + PW'(prod_q[c*CHUNK+k]);
                    end
                end
            end
        end
    end

    logic                 v3_q;
    logic signed [PW-1:0] part_q [MAX_GROUPS][NCHUNK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q <= 1'b0;
            for (int g = 0; g < MAX_GROUPS; g++) begin
                for (int c = 0; c < NCHUNK; c++) begin
                    part_q[g][c] <= '0;
                end
            end
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                for (int g = 0; g < MAX_GROUPS; g++) begin
                    for (int c = 0; c < NCHUNK; c++) begin
                        part_q[g][c] <= part_d[g][c];
                    end
                end
            end
        end
    end

    // Stage 3b: fold chunk partials into the sign-extended group result.
    logic signed [SW-1:0] sum_d [MAX_GROUPS];

    always_comb begin
        for (int g = 0; g < MAX_GROUPS; g++) begin
            sum_d[g] = '0;
            for (int c = 0; c < NCHUNK; c++) begin
                sum_d[g] = sum_d[g] + SW'(part_q[g][c]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            mac_out   <= '0;
        end else begin
            valid_out <= v3_q;
            if (v3_q) begin
                for (int g = 0; g < MAX_GROUPS; g++) begin
                    mac_out[g*SW +: SW] <= sum_d[g];
                end
            end
        end
    end

endmodule

// File: tb/tb_group_mac.sv
// Directed bench for group_mac: hand-computed group sums, latency, hold, boundaries and reset.
module tb_group_mac;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   num_groups;
    logic [47:0]  num_macs_i;
    logic         valid_in;
    logic [511:0] data;
    logic [511:0] weight;
    logic [255:0] mac_out;
    logic         valid_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    group_mac dut (
        .clk        (clk),
        .rst        (rst),
        .num_groups (num_groups),
        .num_macs_i (num_macs_i),
        .valid_in   (valid_in),
        .data       (data),
        .weight     (weight),
        .mac_out    (mac_out),
        .valid_out  (valid_out)
    );

    function automatic logic [47:0] pack_cnt(input int c [8]);
        logic [47:0] r;
        for (int g = 0; g < 8; g++) r[g*6 +: 6] = 6'(c[g]);
        return r;
    endfunction

    function automatic logic [255:0] pack_exp(input int e [8]);
        logic [255:0] r;
        for (int g = 0; g < 8; g++) r[g*32 +: 32] = 32'(e[g]);
        return r;
    endfunction

    function automatic logic [511:0] fill(input int v);
        logic [511:0] r;
        for (int l = 0; l < 64; l++) r[l*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [511:0] set_lane(input logic [511:0] v, input int i, input int x);
        logic [511:0] r;
        r = v;
        r[i*8 +: 8] = 8'(x);
        return r;
    endfunction

    // Reference: walk lanes group by group, dropping lanes past index 63.
    function automatic logic [255:0] golden(input logic [3:0] ng, input logic [47:0] cnt,
                                            input logic [511:0] d, input logic [511:0] w);
        logic [255:0] r;
        int lane;
        int n;
        int s;
        r    = '0;
        lane = 0;
        n    = (int'(ng) > 8) ? 8 : int'(ng);
        for (int g = 0; g < n; g++) begin
            s = 0;
            for (int k = 0; k < int'(cnt[g*6 +: 6]); k++) begin
                if (lane < 64)
                    s += int'($signed(d[lane*8 +: 8])) * int'($signed(w[lane*8 +: 8]));
                lane++;
            end
            r[g*32 +: 32] = 32'(s);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated vector: no pulse for two cycles, pulse with result on the third, then hold.
    task automatic run_one(input string tag, input logic [3:0] ng, input logic [47:0] cnt,
                           input logic [511:0] d, input logic [511:0] w,
                           input logic [255:0] exp);
        num_groups = ng;
        num_macs_i = cnt;
        data       = d;
        weight     = w;
        valid_in   = 1'b1;
        @(posedge clk); #1;
        valid_in   = 1'b0;
        num_groups = 4'd8;
        num_macs_i = '1;
        data       = fill(-1);
        weight     = fill(5);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            chk({tag, "_early"}, 256'(valid_out), 256'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_valid"}, 256'(valid_out), 256'd1);
        chk({tag, "_mac"}, mac_out, exp);
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, 256'(valid_out), 256'd0);
        chk({tag, "_hold"}, mac_out, exp);
    endtask

    logic [511:0] d;
    logic [511:0] w;
    int           ca [8];
    int           ea [8];
    logic [511:0] rd   [10];
    logic [511:0] rw   [10];
    logic [3:0]   rng  [10];
    logic [47:0]  rc   [10];
    logic [255:0] rexp [10];

    initial begin
        rst        = 1'b1;
        valid_in   = 1'b0;
        num_groups = '0;
        num_macs_i = '0;
        data       = '0;
        weight     = '0;
        #12;
        chk("reset_valid", 256'(valid_out), 256'd0);
        chk("reset_mac", mac_out, 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two groups {3,2}; lanes past the active groups hold junk.
        d = fill(7);
        for (int l = 0; l < 5; l++) d = set_lane(d, l, l + 1);
        ca = '{3, 2, 63, 63, 63, 63, 63, 63};
        ea = '{6, 9, 0, 0, 0, 0, 0, 0};
        run_one("t1_two_groups", 4'd2, pack_cnt(ca), d, fill(1), pack_exp(ea));

        d = set_lane(set_lane(fill(0), 0, -128), 1, -128);
        w = set_lane(set_lane(fill(0), 0, -128), 1, 127);
        ca = '{2, 0, 0, 0, 0, 0, 0, 0};
        ea = '{128, 0, 0, 0, 0, 0, 0, 0};
        run_one("t2_sign_pos", 4'd1, pack_cnt(ca), d, w, pack_exp(ea));

        d = set_lane(set_lane(fill(0), 0, 127), 1, 127);
        w = set_lane(set_lane(fill(0), 0, -128), 1, -128);
        ea = '{-32512, 0, 0, 0, 0, 0, 0, 0};
        run_one("t2_sign_neg", 4'd1, pack_cnt(ca), d, w, pack_exp(ea));

        ca = '{8, 8, 8, 8, 8, 8, 8, 8};
        ea = '{131072, 131072, 131072, 131072, 131072, 131072, 131072, 131072};
        run_one("t3_full", 4'd8, pack_cnt(ca), fill(-128), fill(-128), pack_exp(ea));

        // Ten back-to-back random vectors with per-cycle config changes.
        for (int k = 0; k < 10; k++) begin
            rng[k] = 4'($urandom_range(8, 2));
            for (int g = 0; g < 8; g++) rc[k][g*6 +: 6] = 6'($urandom_range(8, 1));
            for (int l = 0; l < 64; l++) begin
                rd[k][l*8 +: 8] = 8'($urandom);
                rw[k][l*8 +: 8] = 8'($urandom);
            end
            rexp[k] = golden(rng[k], rc[k], rd[k], rw[k]);
        end
        for (int s = 0; s < 13; s++) begin
            if (s < 10) begin
                num_groups = rng[s];
                num_macs_i = rc[s];
                data       = rd[s];
                weight     = rw[s];
                valid_in   = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(posedge clk); #1;
            if (s >= 3) begin
                chk($sformatf("t4_valid_%0d", s - 3), 256'(valid_out), 256'd1);
                chk($sformatf("t4_mac_%0d", s - 3), mac_out, rexp[s-3]);
            end else begin
                chk($sformatf("t4_idle_%0d", s), 256'(valid_out), 256'd0);
            end
        end
        @(posedge clk); #1;
        chk("t4_tail", 256'(valid_out), 256'd0);

        // Zero-count group in the middle consumes no lanes.
        d = fill(9);
        for (int l = 0; l < 5; l++) d = set_lane(d, l, l + 1);
        ca = '{2, 0, 3, 7, 7, 7, 7, 7};
        ea = '{3, 0, 12, 0, 0, 0, 0, 0};
        run_one("t5_zero_cnt", 4'd3, pack_cnt(ca), d, fill(1), pack_exp(ea));

        ca = '{5, 5, 5, 5, 5, 5, 5, 5};
        ea = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_one("t5_no_groups", 4'd0, pack_cnt(ca), fill(1), fill(1), pack_exp(ea));

        ca = '{10, 10, 10, 10, 10, 10, 5, 5};
        ea = '{10, 10, 10, 10, 10, 10, 4, 0};
        run_one("t5_overflow", 4'd8, pack_cnt(ca), fill(1), fill(1), pack_exp(ea));

        ca = '{1, 1, 1, 1, 1, 1, 1, 1};
        ea = '{6, 6, 6, 6, 6, 6, 6, 6};
        run_one("t5_clamp", 4'd15, pack_cnt(ca), fill(2), fill(3), pack_exp(ea));

        // Reset with two vectors in flight.
        ca = '{8, 8, 8, 8, 8, 8, 8, 8};
        num_groups = 4'd8;
        num_macs_i = pack_cnt(ca);
        data       = fill(3);
        weight     = fill(3);
        valid_in   = 1'b1;
        @(posedge clk); #1;
        data = fill(4);
        @(posedge clk); #1;
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 256'(valid_out), 256'd0);
        chk("t6_rst_mac", mac_out, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t6_no_stale_%0d", k), 256'(valid_out), 256'd0);
        end
        chk("t6_mac_after", mac_out, 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
